// File: rtl/snake_pkg.sv
// Shared encodings and constants for the snake body engine.
package snake_pkg;

  typedef enum logic [1:0] {
    DIR_UP    = 2'b00,
    DIR_DOWN  = 2'b01,
    DIR_LEFT  = 2'b10,
    DIR_RIGHT = 2'b11
  } dir_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_DEAD = 2'b10
  } state_e;

  localparam int SCREEN_W = 640;
  localparam int SCREEN_H = 480;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int x = v - 1; x > 0; x = x >> 1) r++;
    return r;
  endfunction

  // Opposite directions share bit 1 and differ in bit 0.
  function automatic logic is_reverse(input logic [1:0] a, input logic [1:0] b);
    return (a[1] == b[1]) && (a[0] != b[0]);
  endfunction

endpackage

// File: rtl/snake_next_head.sv
// Combinational move decode: effective direction, next head cell, wall check.
module snake_next_head
  import snake_pkg::*;
#(
  parameter int GRID_W = 80,
  parameter int GRID_H = 60,
  parameter int CW     = 7
) (
  input  logic [1:0]    cur_dir_i,
  input  logic [1:0]    req_dir_i,
  input  logic [CW-1:0] head_x_i,
  input  logic [CW-1:0] head_y_i,
  output logic [1:0]    eff_dir_o,
  output logic [CW-1:0] next_x_o,
  output logic [CW-1:0] next_y_o,
  output logic          wall_o
);

  always_comb begin
    eff_dir_o = is_reverse(req_dir_i, cur_dir_i) ? cur_dir_i : req_dir_i;
    next_x_o  = head_x_i;
    next_y_o  = head_y_i;
    wall_o    = 1'b0;
    case (eff_dir_o)
      DIR_UP: begin
        if (head_y_i == '0) wall_o = 1'b1;
        else                next_y_o = head_y_i - CW'(1);
      end
      DIR_DOWN: begin
        if (head_y_i == CW'(GRID_H - 1)) wall_o = 1'b1;
        else                             next_y_o = head_y_i + CW'(1);
      end
      DIR_LEFT: begin
        if (head_x_i == '0) wall_o = 1'b1;
        else                next_x_o = head_x_i - CW'(1);
      end
      default: begin
        if (head_x_i == CW'(GRID_W - 1)) wall_o = 1'b1;
        else                             next_x_o = head_x_i + CW'(1);
      end
    endcase
  end

endmodule

// File: rtl/snake_body_engine.sv
// Snake segment store, movement/growth FSM, collision detection and pixel hit query.
module snake_body_engine
  import snake_pkg::*;
#(
  parameter int MAX_LEN   = 16,
  parameter int INIT_LEN  = 4,
  parameter int SEG_SHIFT = 3,
  parameter int GRID_W    = 80,
  parameter int GRID_H    = 60,
  parameter int CW        = 7,
  parameter int LW        = clog2(MAX_LEN + 1)
) (
  input  logic          CLK,
  input  logic          reset,
  input  logic          step,
  input  logic          start,
  input  logic [1:0]    dir,
  input  logic          grow,
  input  logic [9:0]    hcount,
  input  logic [9:0]    vcount,
  output logic          pix_head,
  output logic          pix_body,
  output logic [LW-1:0] len,
  output logic [1:0]    state,
  output logic [CW-1:0] head_x,
  output logic [CW-1:0] head_y
);

  logic [CW-1:0] seg_x_q [MAX_LEN];
  logic [CW-1:0] seg_y_q [MAX_LEN];
  state_e        state_q;
  logic [LW-1:0] len_q;
  logic [1:0]    cur_dir_q;
  logic          grow_pend_q;
  logic          pix_head_q, pix_body_q;

  logic [1:0]    eff_dir;
  logic [CW-1:0] nh_x, nh_y;
  logic          wall_hit;

  snake_next_head #(
    .GRID_W(GRID_W),
    .GRID_H(GRID_H),
    .CW    (CW)
  ) u_next_head (
    .cur_dir_i(cur_dir_q),
    .req_dir_i(dir),
    .head_x_i (seg_x_q[0]),
    .head_y_i (seg_y_q[0]),
    .eff_dir_o(eff_dir),
    .next_x_o (nh_x),
    .next_y_o (nh_y),
    .wall_o   (wall_hit)
  );

  logic               grow_eff, grow_apply;
  logic               move, collide, move_ok, reinit;
  logic [MAX_LEN-1:0] active, on_next, is_tail, body_hit, pix_match;
  logic [9:0]         cx, cy;
  logic               on_screen;

  assign grow_eff   = grow_pend_q | grow;
  assign grow_apply = grow_eff && (len_q < LW'(MAX_LEN));
  assign cx         = hcount >> SEG_SHIFT;
  assign cy         = vcount >> SEG_SHIFT;
  assign on_screen  = (hcount < 10'(SCREEN_W)) && (vcount < 10'(SCREEN_H));

  // The tail cell is vacated by this move unless the snake lengthens.
  for (genvar g = 0; g < MAX_LEN; g++) begin : g_seg
    assign active[g]    = LW'(g) < len_q;
    assign on_next[g]   = (seg_x_q[g] == nh_x) && (seg_y_q[g] == nh_y);
    assign is_tail[g]   = LW'(g) == (len_q - LW'(1));
    assign body_hit[g]  = active[g] && on_next[g] && !(is_tail[g] && !grow_apply);
    assign pix_match[g] = (cx == 10'(seg_x_q[g])) && (cy == 10'(seg_y_q[g]));
  end

  assign move    = (state_q == ST_RUN) && step;
  assign collide = wall_hit || (|body_hit);
  assign move_ok = move && !collide;
  assign reinit  = (state_q == ST_DEAD) && start;

  always_ff @(posedge CLK) begin
    if (reset || reinit) begin
      state_q     <= ST_IDLE;
      len_q       <= LW'(INIT_LEN);
      cur_dir_q   <= DIR_RIGHT;
      grow_pend_q <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (grow)  grow_pend_q <= 1'b1;
          if (start) state_q     <= ST_RUN;
        end
        ST_RUN: begin
          if (move) begin
            if (collide) begin
              state_q <= ST_DEAD;
            end else begin
              cur_dir_q <= eff_dir;
              if (grow_eff) begin
                grow_pend_q <= 1'b0;
                if (grow_apply) len_q <= len_q + LW'(1);
              end
            end
          end else if (grow) begin
            grow_pend_q <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (reset || reinit) begin
      for (int i = 0; i < MAX_LEN; i++) begin
        seg_x_q[i] <= (i < INIT_LEN) ? CW'(GRID_W / 2 - i) : '0;
        seg_y_q[i] <= (i < INIT_LEN) ? CW'(GRID_H / 2) : '0;
      end
    end else if (move_ok) begin
      seg_x_q[0] <= nh_x;
      seg_y_q[0] <= nh_y;
      for (int i = 1; i < MAX_LEN; i++) begin
        seg_x_q[i] <= seg_x_q[i-1];
        seg_y_q[i] <= seg_y_q[i-1];
      end
    end
  end

  // Pixel query stage: one register between beam position and hit flags.
  always_ff @(posedge CLK) begin
    if (reset) begin
      pix_head_q <= 1'b0;
      pix_body_q <= 1'b0;
    end else begin
      pix_head_q <= on_screen && pix_match[0];
      pix_body_q <= on_screen && (|(pix_match[MAX_LEN-1:1] & active[MAX_LEN-1:1]));
    end
  end

  assign pix_head = pix_head_q;
  assign pix_body = pix_body_q;
  assign len      = len_q;
  assign state    = state_q;
  assign head_x   = seg_x_q[0];
  assign head_y   = seg_y_q[0];

endmodule

// File: tb/tb_snake_body_engine.sv
// Randomized and directed bench for snake_body_engine against a cell-list reference model.
module tb_snake_body_engine;

  localparam int MAXL  = 16;
  localparam int INITL = 4;

  logic       CLK;
  logic       reset, step, start, grow;
  logic [1:0] dir;
  logic [9:0] hcount, vcount;
  logic       pix_head, pix_body;
  logic [4:0] len;
  logic [1:0] state;
  logic [6:0] head_x, head_y;

  snake_body_engine dut (
    .CLK     (CLK),
    .reset   (reset),
    .step    (step),
    .start   (start),
    .dir     (dir),
    .grow    (grow),
    .hcount  (hcount),
    .vcount  (vcount),
    .pix_head(pix_head),
    .pix_body(pix_body),
    .len     (len),
    .state   (state),
    .head_x  (head_x),
    .head_y  (head_y)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int n_cmp = 0;
  int n_err = 0;

  // Reference snake: ordered list of occupied cells, head first.
  int qx[$];
  int qy[$];
  int m_state;
  int m_dir;
  bit m_pend;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int opp(input int d);
    case (d)
      0: return 1;
      1: return 0;
      2: return 3;
      default: return 2;
    endcase
  endfunction

  task automatic mreset();
    qx.delete();
    qy.delete();
    for (int i = 0; i < INITL; i++) begin
      qx.push_back(40 - i);
      qy.push_back(30);
    end
    m_state = 0;
    m_dir   = 3;
    m_pend  = 1'b0;
  endtask

  task automatic tick(input bit r, input bit s, input bit st, input int d, input bit g,
                      input int hc, input int vc);
    bit eph, epb, grw, hit, ge;
    int cx, cy, nx, ny, eff, lim;
    @(negedge CLK);
    reset = r; step = s; start = st; dir = 2'(d); grow = g;
    hcount = 10'(hc); vcount = 10'(vc);
    eph = 1'b0; epb = 1'b0;
    if (!r && hc < 640 && vc < 480) begin
      cx = hc >> 3;
      cy = vc >> 3;
      for (int i = 0; i < qx.size(); i++)
        if (qx[i] == cx && qy[i] == cy) begin
          if (i == 0) eph = 1'b1;
          else        epb = 1'b1;
        end
    end
    @(posedge CLK);
    if (r) begin
      mreset();
    end else begin
      case (m_state)
        0: begin
          if (g)  m_pend  = 1'b1;
          if (st) m_state = 1;
        end
        1: begin
          if (s) begin
            eff = (d == opp(m_dir)) ? m_dir : d;
            nx = qx[0];
            ny = qy[0];
            case (eff)
              0: ny = ny - 1;
              1: ny = ny + 1;
              2: nx = nx - 1;
              default: nx = nx + 1;
            endcase
            ge  = m_pend || g;
            grw = ge && (qx.size() < MAXL);
            hit = (nx < 0) || (nx >= 80) || (ny < 0) || (ny >= 60);
            lim = grw ? qx.size() : qx.size() - 1;
            for (int i = 0; i < lim; i++)
              if (qx[i] == nx && qy[i] == ny) hit = 1'b1;
            if (hit) begin
              m_state = 2;
            end else begin
              qx.push_front(nx);
              qy.push_front(ny);
              if (!grw) begin
                void'(qx.pop_back());
                void'(qy.pop_back());
              end
              m_dir = eff;
              if (ge) m_pend = 1'b0;
            end
          end else if (g) begin
            m_pend = 1'b1;
          end
        end
        default: if (st) mreset();
      endcase
    end
    #1;
    check("state", 32'(state), 32'(m_state));
    check("len", 32'(len), 32'(qx.size()));
    check("head_x", 32'(head_x), 32'(qx[0]));
    check("head_y", 32'(head_y), 32'(qy[0]));
    check("pix_head", 32'(pix_head), 32'(eph));
    check("pix_body", 32'(pix_body), 32'(epb));
  endtask

  task automatic mv(input bit s, input bit st, input int d, input bit g);
    tick(1'b0, s, st, d, g, int'($urandom_range(0, 639)), int'($urandom_range(0, 479)));
  endtask

  initial begin
    int k, hc, vc;
    reset = 1'b1; step = 1'b0; start = 1'b0; grow = 1'b0;
    dir = 2'b00; hcount = '0; vcount = '0;
    mreset();

    tick(1, 0, 0, 0, 0, 0, 0);
    tick(1, 0, 0, 0, 0, 0, 0);
    check("rst_pix_head", 32'(pix_head), 0);

    mv(0, 1, 3, 0);
    for (int i = 0; i < 3; i++) mv(1, 0, 3, 0);
    check("t1_head_x", 32'(head_x), 43);
    check("t1_len", 32'(len), 4);
    tick(0, 0, 0, 3, 0, 344, 240);
    tick(0, 0, 0, 3, 0, 0, 0);
    check("t1_pix_head_delayed", 32'(pix_head), 0);

    mv(1, 0, 2, 0);
    check("t2_reverse_x", 32'(head_x), 44);
    check("t2_state", 32'(state), 1);

    mv(0, 0, 3, 1);
    mv(1, 0, 3, 0);
    check("t3_grow_len", 32'(len), 5);
    for (int i = 0; i < 20; i++) mv(1, 0, 3, 1);
    check("t3_len_sat", 32'(len), 16);

    while (head_x != 7'd79 && n_cmp < 5000) mv(1, 0, 3, 0);
    mv(1, 0, 3, 0);
    check("t4_dead", 32'(state), 2);
    check("t4_head_kept", 32'(head_x), 79);
    mv(1, 0, 3, 1);
    mv(0, 1, 3, 0);
    check("t4_idle", 32'(state), 0);
    check("t4_len", 32'(len), 4);
    check("t4_head_x", 32'(head_x), 40);

    mv(0, 1, 3, 0);
    mv(1, 0, 3, 1);
    mv(1, 0, 0, 0);
    mv(1, 0, 2, 0);
    mv(1, 0, 1, 0);
    check("t5_self_hit", 32'(state), 2);
    mv(0, 1, 0, 0);
    mv(0, 1, 3, 0);
    mv(1, 0, 3, 0);
    mv(1, 0, 0, 0);
    mv(1, 0, 2, 0);
    mv(1, 0, 1, 0);
    mv(1, 0, 3, 0);
    check("t5_tail_follow", 32'(state), 1);
    check("t5_head_x", 32'(head_x), 41);

    tick(1, 1, 0, 3, 1, 0, 0);
    check("t6_rst_state", 32'(state), 0);
    check("t6_rst_head_x", 32'(head_x), 40);
    mv(1, 1, 3, 0);
    check("t6_start_wins_state", 32'(state), 1);
    check("t6_start_wins_x", 32'(head_x), 40);

    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 1) == 1) begin
        k  = int'($urandom_range(0, qx.size() - 1));
        hc = qx[k] * 8 + int'($urandom_range(0, 7));
        vc = qy[k] * 8 + int'($urandom_range(0, 7));
      end else begin
        hc = int'($urandom_range(0, 700));
        vc = int'($urandom_range(0, 520));
      end
      tick($urandom_range(0, 199) == 0, $urandom_range(0, 3) == 0,
           $urandom_range(0, 15) == 0, int'($urandom_range(0, 3)),
           $urandom_range(0, 7) == 0, hc, vc);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
